// File: rtl/mem_map_pkg.sv
// Memory map shared by the CPU memory controller, the memory-side responder and the testbench.
// Holds the IO window layout, the STATUS bit positions and the address decode helper.
package mem_map_pkg;

   localparam int unsigned ADDR_W_DEF  = 17;
   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

   localparam logic [31:0] OFS_TXDATA = 32'd0;
   localparam logic [31:0] OFS_STATUS = 32'd1;
   localparam logic [31:0] OFS_HALT   = 32'd4;

   localparam int STAT_OVF_BIT  = 7;
   localparam int STAT_HALT_BIT = 6;
   localparam int STAT_CNT_W    = 6;

   typedef enum logic [2:0] {
      RGN_RAM,
      RGN_TXDATA,
      RGN_STATUS,
      RGN_HALT,
      RGN_NONE
   } region_e;

   // RAM occupies 0 .. 2**addr_w-1; the IO window sits above it
   function automatic region_e decode_addr(input logic [31:0] a,
                                           input int unsigned addr_w,
                                           input logic [31:0] io_base);
      if ((a >> addr_w) == 32'd0)        return RGN_RAM;
      if (a == io_base + OFS_TXDATA)     return RGN_TXDATA;
      if (a == io_base + OFS_STATUS)     return RGN_STATUS;
      if (a == io_base + OFS_HALT)       return RGN_HALT;
      return RGN_NONE;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte queue with first-word-fall-through head output.
// Pointers carry one extra wrap bit so full and empty are distinguished without a separate flag.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               din,
   output logic                     full,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          pop_ok;
   logic          push_ok;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   // a pop frees the slot this cycle, so a full queue still accepts a simultaneous push
   assign push_ok = push && (!full || pop_ok);
   assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; empty pointers already make its contents unobservable.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mem_byte_responder.sv
// Sole slave on the byte-serial memory bus: RAM with fixed read latency plus a small IO window
// (TX byte queue, queue status, sticky halt).
module mem_byte_responder
   import mem_map_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int          READ_LAT = 1,
   parameter int          TX_DEPTH = 16,
   parameter logic [31:0] IO_BASE  = IO_BASE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic        wr,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt,
   output logic        tx_ovf
);

   localparam int CW = $clog2(TX_DEPTH) + 1;

   region_e             region;
   logic [ADDR_W-1:0]   idx;
   logic                push;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CW-1:0]       tx_count;
   logic [5:0]          cnt_sat;
   logic [7:0]          status;
   logic [7:0]          io_rdata;

   logic [7:0]          mem [2**ADDR_W];
   logic [7:0]          ram_q;
   logic                sel_ram_q;
   logic [7:0]          io_q;
   logic [7:0]          rd_sel;

   assign region   = decode_addr(a, ADDR_W, IO_BASE);
   assign idx      = a[ADDR_W-1:0];
   assign push     = (region == RGN_TXDATA) && wr;
   assign pop      = tx_valid && tx_ready;
   assign tx_valid = !fifo_empty;

   byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (din),
      .full  (fifo_full),
      .pop   (pop),
      .dout  (tx_data),
      .empty (fifo_empty),
      .count (tx_count)
   );

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      cnt_sat  = 6'(tx_count);
      if (32'(tx_count) > 32'd63) cnt_sat = 6'd63;
      status                          = 8'h00;
      status[STAT_OVF_BIT]            = tx_ovf;
      status[STAT_HALT_BIT]           = halt;
      status[STAT_CNT_W-1:0]          = cnt_sat;
      io_rdata = 8'h00;
      case (region)
         RGN_STATUS: io_rdata = status;
         RGN_HALT:   io_rdata = {7'b0, halt};
         default:    io_rdata = 8'h00;
      endcase
   end

   // Synchronous-read RAM; writes are suppressed while rst is asserted
   always_ff @(posedge clk) begin
      if (!rst && region == RGN_RAM && wr) mem[idx] <= din;
      ram_q <= mem[idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_ram_q <= 1'b0;
         io_q      <= 8'h00;
         halt      <= 1'b0;
         tx_ovf    <= 1'b0;
      end else begin
         sel_ram_q <= (region == RGN_RAM) && !wr;
         io_q      <= wr ? 8'h00 : io_rdata;
         if (region == RGN_HALT && wr)     halt   <= 1'b1;
         if (push && fifo_full && !pop)    tx_ovf <= 1'b1;
      end
   end

   assign rd_sel = sel_ram_q ? ram_q : io_q;

   // Extra delay stages bring the total read latency up to READ_LAT
   generate
      if (READ_LAT == 1) begin : g_lat1
         assign dout = rd_sel;
      end else begin : g_latn
         logic [7:0] dly [READ_LAT-1];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < READ_LAT - 1; i++) dly[i] <= 8'h00;
            end else begin
               dly[0] <= rd_sel;
               for (int i = 1; i < READ_LAT - 1; i++) dly[i] <= dly[i-1];
            end
         end
         assign dout = dly[READ_LAT-2];
      end
   endgenerate

endmodule

// File: tb/tb_mem_byte_responder.sv
// Scoreboard bench for mem_byte_responder: three instances (READ_LAT 1..3) share one bus,
// a behavioural model predicts every dout slot and the TX/flag outputs.
module tb_mem_byte_responder;
   import mem_map_pkg::*;

   localparam int          TX_DEPTH = 16;
   localparam int unsigned ADDR_W   = 17;
   localparam logic [31:0] IO       = IO_BASE_DEF;
   localparam logic [31:0] UNMAP    = 32'h0004_0000;
   localparam logic [31:0] IDLE_A   = 32'hFFFF_0000;

   typedef struct packed {
      logic [7:0] v;
      logic       known;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a   = IDLE_A;
   logic        wr  = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        tx_ready = 1'b0;

   logic [7:0]  dout_v     [3];
   logic [7:0]  tx_data_v  [3];
   logic        tx_valid_v [3];
   logic        halt_v     [3];
   logic        tx_ovf_v   [3];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_byte_responder #(.ADDR_W(ADDR_W), .READ_LAT(1), .TX_DEPTH(TX_DEPTH), .IO_BASE(IO)) u_lat1 (
      .clk(clk), .rst(rst), .a(a), .wr(wr), .din(din), .dout(dout_v[0]),
      .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]), .tx_ready(tx_ready),
      .halt(halt_v[0]), .tx_ovf(tx_ovf_v[0]));
   mem_byte_responder #(.ADDR_W(ADDR_W), .READ_LAT(2), .TX_DEPTH(TX_DEPTH), .IO_BASE(IO)) u_lat2 (
      .clk(clk), .rst(rst), .a(a), .wr(wr), .din(din), .dout(dout_v[1]),
      .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]), .tx_ready(tx_ready),
      .halt(halt_v[1]), .tx_ovf(tx_ovf_v[1]));
   mem_byte_responder #(.ADDR_W(ADDR_W), .READ_LAT(3), .TX_DEPTH(TX_DEPTH), .IO_BASE(IO)) u_lat3 (
      .clk(clk), .rst(rst), .a(a), .wr(wr), .din(din), .dout(dout_v[2]),
      .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]), .tx_ready(tx_ready),
      .halt(halt_v[2]), .tx_ovf(tx_ovf_v[2]));

   // ---------------- reference model ----------------
   logic [7:0] mem_m [int];
   logic [7:0] tx_q  [$];
   logic       halt_m = 1'b0;
   logic       ovf_m  = 1'b0;
   exp_t       q1 [$];
   exp_t       q2 [$];
   exp_t       q3 [$];

   task automatic push_all(input exp_t e);
      q1.push_back(e);
      q2.push_back(e);
      q3.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      bit   popped;
      int   cnt;
      if (rst) begin
         tx_q.delete();
         halt_m = 1'b0;
         ovf_m  = 1'b0;
         q1.delete(); q2.delete(); q3.delete();
         e = '{v: 8'h00, known: 1'b1};
         q1.push_back(e);
         repeat (2) q2.push_back(e);
         repeat (3) q3.push_back(e);
      end else begin
         e   = '{v: 8'h00, known: 1'b1};
         cnt = (tx_q.size() > 63) ? 63 : tx_q.size();
         if (a < (32'd1 << ADDR_W)) begin
            if (!wr) begin
               if (mem_m.exists(int'(a))) e.v = mem_m[int'(a)];
               else                       e.known = 1'b0;
            end
         end else if (a == IO + 32'd1 && !wr) begin
            e.v = {ovf_m, halt_m, 6'(cnt)};
         end else if (a == IO + 32'd4 && !wr) begin
            e.v = {7'b0, halt_m};
         end
         push_all(e);

         popped = 1'b0;
         if (tx_ready && tx_q.size() > 0) begin
            void'(tx_q.pop_front());
            popped = 1'b1;
         end
         if (a < (32'd1 << ADDR_W) && wr) mem_m[int'(a)] = din;
         if (a == IO && wr) begin
            if (tx_q.size() < TX_DEPTH) tx_q.push_back(din);
            else                        ovf_m = 1'b1;
         end
         if (a == IO + 32'd4 && wr) halt_m = 1'b1;
         if (popped && tx_q.size() == TX_DEPTH - 1 && a == IO && wr) begin
            // full-and-pop case is already covered above: the pop made room first
         end
      end
   end

   // ---------------- monitor ----------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q1.size() >= 1) begin
         e = q1.pop_front();
         if (e.known) check("dout_lat1", dout_v[0], e.v);
      end
      if (q2.size() >= 2) begin
         e = q2.pop_front();
         if (e.known) check("dout_lat2", dout_v[1], e.v);
      end
      if (q3.size() >= 3) begin
         e = q3.pop_front();
         if (e.known) check("dout_lat3", dout_v[2], e.v);
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("tx_valid[%0d]", i), {7'b0, tx_valid_v[i]}, {7'b0, tx_q.size() != 0});
         if (tx_q.size() != 0) check($sformatf("tx_data[%0d]", i), tx_data_v[i], tx_q[0]);
         else if (rst)         check($sformatf("tx_data_rst[%0d]", i), tx_data_v[i], 8'h00);
         check($sformatf("halt[%0d]", i), {7'b0, halt_v[i]}, {7'b0, halt_m});
         check($sformatf("tx_ovf[%0d]", i), {7'b0, tx_ovf_v[i]}, {7'b0, ovf_m});
      end
   end

   // ---------------- stimulus ----------------
   task automatic acc(input logic [31:0] addr, input logic w, input logic [7:0] d);
      a   = addr;
      wr  = w;
      din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) acc(IDLE_A, 1'b0, 8'h00);
   endtask

   initial begin
      logic [7:0] msg [2];
      msg[0] = 8'h48;
      msg[1] = 8'h69;

      idle(3);
      rst = 1'b0;

      // consecutive RAM stream
      for (int i = 0; i < 4; i++) acc(32'h100 + 32'(i), 1'b1, 8'h11 * 8'(i + 1));
      for (int i = 0; i < 4; i++) acc(32'h100 + 32'(i), 1'b0, 8'h00);
      idle(3);

      // write then immediate read
      acc(32'h200, 1'b1, 8'hA5);
      acc(32'h200, 1'b0, 8'h00);
      idle(3);

      // TX queue basic
      tx_ready = 1'b0;
      for (int i = 0; i < 2; i++) acc(IO, 1'b1, msg[i]);
      acc(IO + 32'd1, 1'b0, 8'h00);
      acc(IO, 1'b0, 8'h00);
      tx_ready = 1'b1;
      idle(4);

      // overflow with no consumer
      tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) acc(IO, 1'b1, 8'h80 + 8'(i));
      acc(IO + 32'd1, 1'b0, 8'h00);
      tx_ready = 1'b1;
      idle(20);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;

      // full queue with simultaneous pop on the 17th push
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) acc(IO, 1'b1, 8'hC0 + 8'(i));
      tx_ready = 1'b1;
      acc(IO, 1'b1, 8'hD0);
      tx_ready = 1'b0;
      acc(IO + 32'd1, 1'b0, 8'h00);
      tx_ready = 1'b1;
      idle(20);

      // empty queue, push with ready high
      acc(IO, 1'b1, 8'h5A);
      idle(3);

      // halt and unmapped space
      acc(IO + 32'd4, 1'b1, 8'h00);
      acc(IO + 32'd4, 1'b0, 8'h00);
      acc(UNMAP, 1'b0, 8'h00);
      acc(UNMAP, 1'b1, 8'hFF);
      acc(32'h100, 1'b0, 8'h00);
      acc(IO + 32'd1, 1'b0, 8'h00);
      idle(3);

      // reset in the middle of traffic, including a write during reset
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) acc(IO, 1'b1, 8'h30 + 8'(i));
      acc(32'h100, 1'b0, 8'h00);
      rst = 1'b1;
      acc(32'h100, 1'b1, 8'h99);
      rst = 1'b0;
      idle(3);
      acc(32'h100, 1'b0, 8'h00);
      idle(3);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         int r;
         r        = int'($urandom_range(0, 9));
         tx_ready = ($urandom_range(0, 3) != 0);
         case (r)
            0, 1, 2, 3: acc(32'h100 + 32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                            8'($urandom));
            4, 5:       acc(IO, 1'b1, 8'($urandom));
            6:          acc(IO + 32'd1, 1'($urandom_range(0, 1)), 8'($urandom));
            7:          acc(IO + 32'd4, ($urandom_range(0, 31) == 0), 8'($urandom));
            default:    acc(UNMAP + 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                            8'($urandom));
         endcase
         if (n == 400) begin
            rst = 1'b1;
            idle(1);
            rst = 1'b0;
         end
      end
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
